id_stage_param: RTL and testbench
=================================

// Module: id_stage_param
// PURPOSE
//   Parametrised instruction-decode stage: register file, immediate extender and branch-target adder, registered into an ID/EX pipeline register.
//   Adds stall/flush control, optional WB->ID write bypass and a nested exception-PC stack for siic/rti.
//   Sits between the IF/ID register and the execute stage.
// PARAMETERS
//   DATA_W     16  datapath width (register, PC and immediate width); must be >= 16
//   EPC_DEPTH   2  exception-PC stack entries (nested siic levels); must be >= 1
//   BYPASS      1  1: a read of the register being written this cycle returns wb_data; 0: returns the old value
// PORTS
//   clk         in   1        clock, rising edge
//   rst         in   1        synchronous reset, active-low
//   stall       in   1        hold the ID/EX register and EPC stack
//   flush       in   1        load a bubble into ID/EX
//   valid_in    in   1        instr_in is a real instruction
//   instr_in    in   16       instruction from IF/ID
//   pc_add2_in  in   DATA_W   PC+2 of instr_in
//   imm_sel     in   2        immediate field: 00=[4:0], 01=[7:0], 10=[10:0], 11=zero
//   imm_sign    in   1        1 = sign-extend, 0 = zero-extend
//   reg_dst     in   2        destination select: 00=[7:5], 01=[4:2], 10=[10:8], 11=3'd7
//   wb_we       in   1        register-file write enable from WB
//   wb_sel      in   3        register-file write index
//   wb_data     in   DATA_W   register-file write data
//   valid_out   out  1        ID/EX holds a real instruction
//   rs_data     out  DATA_W   value of R[instr[10:8]]
//   rt_data     out  DATA_W   value of R[instr[7:5]]
//   imm_out     out  DATA_W   extended immediate
//   br_target   out  DATA_W   pc_add2 + imm (branch target)
//   rs_sel      out  3        instr[10:8]
//   rt_sel      out  3        instr[7:5]
//   rd_sel      out  3        destination index chosen by reg_dst
//   is_siic     out  1        registered: instruction is siic (instr[15:11]==5'b00010)
//   is_rti      out  1        registered: instruction is rti (instr[15:11]==5'b00011)
//   epc         out  DATA_W   top of the EPC stack; 0 when the stack is empty
//   in_handler  out  1        EPC stack is non-empty
//   exc_err     out  1        sticky: EPC stack overflow or underflow
// BEHAVIOUR
//   - Reset (rst==0 at a clock edge):
//     - all registers R0..R7 = 0; every ID/EX output = 0
//     - EPC stack empty (count = 0), epc = 0, in_handler = 0, exc_err = 0
//   - Register writes:
//     - 8 x DATA_W entries; write at the clock edge when wb_we=1
//     - writes proceed regardless of stall or flush; R0 is an ordinary register
//   - Reads: combinational, then registered into ID/EX, so ID/EX latency is 1 cycle.
//     - BYPASS=1 and wb_we=1 with wb_sel equal to a read index: that read takes wb_data
//   - Immediate: the selected field is extended to DATA_W per imm_sign; imm_sel=11 gives 0.
//   - br_target = pc_add2_in + imm, modulo 2^DATA_W; carry-out is discarded.
//   - Per-edge ID/EX update priority:
//     - rst = 0: reset as above
//     - flush = 1: valid_out = 0 and all other ID/EX outputs = 0
//     - stall = 1: hold every ID/EX output
//     - otherwise: load; valid_out = valid_in
//   - EPC stack acts only when valid_in=1, stall=0 and flush=0.
//   - siic:
//     - count < EPC_DEPTH: push pc_add2_in, count+1
//     - count == EPC_DEPTH: no push, exc_err = 1
//   - rti:
//     - count > 0: pop, count-1
//     - count == 0: no change to stack or epc, exc_err = 1
//   - siic and rti are mutually exclusive by encoding.
//   - epc and in_handler are updated at the same edge as the push or pop.
//   - exc_err is cleared only by reset.
// TESTING
//   1. Reset, then write R3=0x1234 and read instr rs=3: rs_data=0x1234 one cycle after the read edge; all outputs 0 while reset is held.
//   2. BYPASS=1: wb_we=1, wb_sel=5, wb_data=0xBEEF in the same cycle as a read of rt=5 -> rt_data=0xBEEF; with BYPASS=0 -> old value 0.
//   3. pc_add2=0xFFFE, imm_sel=01, imm_sign=1, instr[7:0]=0x04 -> imm_out=0x0004, br_target=0x0002 (wrap). Same field 0x80 -> imm_out 0xFF80 signed, 0x0080 unsigned.
//   4. stall=1 for 3 cycles while the instruction changes -> outputs frozen; flush=1 together with stall=1 -> valid_out=0 next cycle.
//   5. EPC_DEPTH=2: siic at pc 0x10, then siic at 0x20 -> epc=0x20; rti -> epc=0x10; rti -> in_handler=0, epc=0. A third siic while full -> exc_err=1.
//   6. rti with an empty stack -> exc_err=1, epc stays 0. A siic with stall=1 -> no push; reset mid-handler -> stack empty.

Source files
------------

// File: rtl/id_stage_param.sv
// Decode stage: register file, immediate extend, branch target,
// ID/EX register with stall/flush and a nested exception-PC stack.
module id_stage_param #(
   parameter int DATA_W    = 16,
   parameter int EPC_DEPTH = 2,
   parameter int BYPASS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              valid_in,
   input  logic [15:0]       instr_in,
   input  logic [DATA_W-1:0] pc_add2_in,
   input  logic [1:0]        imm_sel,
   input  logic              imm_sign,
   input  logic [1:0]        reg_dst,
   input  logic              wb_we,
   input  logic [2:0]        wb_sel,
   input  logic [DATA_W-1:0] wb_data,
   output logic              valid_out,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic [DATA_W-1:0] imm_out,
   output logic [DATA_W-1:0] br_target,
   output logic [2:0]        rs_sel,
   output logic [2:0]        rt_sel,
   output logic [2:0]        rd_sel,
   output logic              is_siic,
   output logic              is_rti,
   output logic [DATA_W-1:0] epc,
   output logic              in_handler,
   output logic              exc_err
);

   localparam int CW = $clog2(EPC_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(EPC_DEPTH);
   localparam bit BYP = (BYPASS != 0);

   logic [DATA_W-1:0] rf_q [8];

   logic              valid_q;
   logic [DATA_W-1:0] rs_q, rt_q, imm_q, br_q;
   logic [2:0]        rss_q, rts_q, rds_q;
   logic              siic_q, rti_q;

   logic [DATA_W-1:0] stk_q [EPC_DEPTH];
   logic [DATA_W-1:0] stk_d [EPC_DEPTH];
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;

   logic [2:0]        rs_idx, rt_idx, rd_d;
   logic [DATA_W-1:0] rs_d, rt_d, imm_d, br_d;
   logic              siic_d, rti_d, act;

   assign rs_idx = instr_in[10:8];
   assign rt_idx = instr_in[7:5];
   assign siic_d = (instr_in[15:11] == 5'b00010);
   assign rti_d  = (instr_in[15:11] == 5'b00011);
   assign act    = valid_in & ~stall & ~flush;

   // Bypass lets a same-cycle WB write be seen without a stall.
   assign rs_d = (BYP && wb_we && wb_sel == rs_idx) ? wb_data : rf_q[rs_idx];
   assign rt_d = (BYP && wb_we && wb_sel == rt_idx) ? wb_data : rf_q[rt_idx];
   assign br_d = pc_add2_in + imm_d;

   always_comb begin
      imm_d = '0;
      unique case (imm_sel)
         2'b00: imm_d = {{(DATA_W-5){imm_sign & instr_in[4]}}, instr_in[4:0]};
         2'b01: imm_d = {{(DATA_W-8){imm_sign & instr_in[7]}}, instr_in[7:0]};
         2'b10: imm_d = {{(DATA_W-11){imm_sign & instr_in[10]}}, instr_in[10:0]};
         default: imm_d = '0;
      endcase
   end

   always_comb begin
      rd_d = 3'd7;
      unique case (reg_dst)
         2'b00: rd_d = instr_in[7:5];
         2'b01: rd_d = instr_in[4:2];
         2'b10: rd_d = instr_in[10:8];
         default: rd_d = 3'd7;
      endcase
   end

   // Stack entry 0 is the top; pops shift zeros in so epc reads 0 when empty.
   always_comb begin
      stk_d = stk_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (act && siic_d) begin
         if (cnt_q == FULL) begin
            err_d = 1'b1;
         end else begin
            for (int i = 1; i < EPC_DEPTH; i++) stk_d[i] = stk_q[i-1];
            stk_d[0] = pc_add2_in;
            cnt_d = cnt_q + CW'(1);
         end
      end else if (act && rti_d) begin
         if (cnt_q == '0) begin
            err_d = 1'b1;
         end else begin
            for (int i = 0; i < EPC_DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
            stk_d[EPC_DEPTH-1] = '0;
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else if (wb_we) begin
         rf_q[wb_sel] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         valid_q <= 1'b0;
         rs_q    <= '0;
         rt_q    <= '0;
         imm_q   <= '0;
         br_q    <= '0;
         rss_q   <= '0;
         rts_q   <= '0;
         rds_q   <= '0;
         siic_q  <= 1'b0;
         rti_q   <= 1'b0;
      end else if (!stall) begin
         valid_q <= valid_in;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         imm_q   <= imm_d;
         br_q    <= br_d;
         rss_q   <= rs_idx;
         rts_q   <= rt_idx;
         rds_q   <= rd_d;
         siic_q  <= siic_d;
         rti_q   <= rti_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < EPC_DEPTH; i++) stk_q[i] <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         stk_q <= stk_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign valid_out  = valid_q;
   assign rs_data    = rs_q;
   assign rt_data    = rt_q;
   assign imm_out    = imm_q;
   assign br_target  = br_q;
   assign rs_sel     = rss_q;
   assign rt_sel     = rts_q;
   assign rd_sel     = rds_q;
   assign is_siic    = siic_q;
   assign is_rti     = rti_q;
   assign epc        = stk_q[0];
   assign in_handler = (cnt_q != '0);
   assign exc_err    = err_q;

endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for id_stage_param: a BYPASS=1 instance plus a
// BYPASS=0 instance sharing the same stimulus.
module tb_id_stage_param;

   logic        clk = 1'b0;
   logic        rst, stall, flush, valid_in, imm_sign, wb_we;
   logic [15:0] instr_in, pc_add2_in, wb_data;
   logic [1:0]  imm_sel, reg_dst;
   logic [2:0]  wb_sel;

   logic        valid_out, is_siic, is_rti, in_handler, exc_err;
   logic [15:0] rs_data, rt_data, imm_out, br_target, epc;
   logic [2:0]  rs_sel, rt_sel, rd_sel;

   logic        n_valid, n_siic, n_rti, n_inh, n_err;
   logic [15:0] n_rs, n_rt, n_imm, n_br, n_epc;
   logic [2:0]  n_rss, n_rts, n_rds;

   int vec = 0;
   int miss = 0;

   always #5 clk = ~clk;

   id_stage_param #(.DATA_W(16), .EPC_DEPTH(2), .BYPASS(1)) u_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .valid_in(valid_in), .instr_in(instr_in), .pc_add2_in(pc_add2_in),
      .imm_sel(imm_sel), .imm_sign(imm_sign), .reg_dst(reg_dst),
      .wb_we(wb_we), .wb_sel(wb_sel), .wb_data(wb_data),
      .valid_out(valid_out), .rs_data(rs_data), .rt_data(rt_data),
      .imm_out(imm_out), .br_target(br_target), .rs_sel(rs_sel),
      .rt_sel(rt_sel), .rd_sel(rd_sel), .is_siic(is_siic), .is_rti(is_rti),
      .epc(epc), .in_handler(in_handler), .exc_err(exc_err)
   );

   id_stage_param #(.DATA_W(16), .EPC_DEPTH(2), .BYPASS(0)) u_nb (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .valid_in(valid_in), .instr_in(instr_in), .pc_add2_in(pc_add2_in),
      .imm_sel(imm_sel), .imm_sign(imm_sign), .reg_dst(reg_dst),
      .wb_we(wb_we), .wb_sel(wb_sel), .wb_data(wb_data),
      .valid_out(n_valid), .rs_data(n_rs), .rt_data(n_rt),
      .imm_out(n_imm), .br_target(n_br), .rs_sel(n_rss),
      .rt_sel(n_rts), .rd_sel(n_rds), .is_siic(n_siic), .is_rti(n_rti),
      .epc(n_epc), .in_handler(n_inh), .exc_err(n_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; flush = 0; valid_in = 0; instr_in = 16'h0000;
      pc_add2_in = 16'h0000; imm_sel = 2'b11; imm_sign = 0; reg_dst = 2'b00;
      wb_we = 0; wb_sel = 3'd0; wb_data = 16'h0000;
   endtask

   task automatic do_reset();
      idle();
      rst = 0;
      step();
      step();
      rst = 1;
   endtask

   task automatic test_reset();
      idle();
      rst = 0;
      valid_in = 1; instr_in = 16'h1000; pc_add2_in = 16'h0040;
      imm_sel = 2'b01; instr_in[7:0] = 8'h7F;
      wb_we = 1; wb_sel = 3'd1; wb_data = 16'hAAAA;
      step(); step();
      vec++; if (valid_out !== 1'b0) begin miss++; $display("FAIL rst_valid got=%b exp=0", valid_out); end
      vec++; if (imm_out !== 16'h0) begin miss++; $display("FAIL rst_imm got=%h exp=0000", imm_out); end
      vec++; if (br_target !== 16'h0) begin miss++; $display("FAIL rst_br got=%h exp=0000", br_target); end
      vec++; if (is_siic !== 1'b0) begin miss++; $display("FAIL rst_siic got=%b exp=0", is_siic); end
      vec++; if ({epc, in_handler, exc_err} !== 18'h0) begin miss++; $display("FAIL rst_epc got=%h/%b/%b exp=0", epc, in_handler, exc_err); end
      rst = 1;
      idle();
      wb_we = 1; wb_sel = 3'd3; wb_data = 16'h1234;
      step();
      idle();
      valid_in = 1; instr_in = 16'h0300;
      step();
      vec++; if (rs_data !== 16'h1234) begin miss++; $display("FAIL r3_read got=%h exp=1234", rs_data); end
      vec++; if (valid_out !== 1'b1 || rs_sel !== 3'd3) begin miss++; $display("FAIL r3_valid got=%b/%0d exp=1/3", valid_out, rs_sel); end
      instr_in = 16'h0100;
      step();
      vec++; if (rs_data !== 16'h0000) begin miss++; $display("FAIL r1_no_write_in_reset got=%h exp=0000", rs_data); end
      valid_in = 0;
      step();
      vec++; if (valid_out !== 1'b0) begin miss++; $display("FAIL valid_in0 got=%b exp=0", valid_out); end
   endtask

   task automatic test_bypass();
      idle();
      valid_in = 1; instr_in = 16'h00A0;
      wb_we = 1; wb_sel = 3'd5; wb_data = 16'hBEEF;
      step();
      vec++; if (rt_data !== 16'hBEEF) begin miss++; $display("FAIL bypass1 got=%h exp=beef", rt_data); end
      vec++; if (n_rt !== 16'h0000) begin miss++; $display("FAIL bypass0 got=%h exp=0000", n_rt); end
      vec++; if (rt_sel !== 3'd5) begin miss++; $display("FAIL rt_sel got=%0d exp=5", rt_sel); end
      wb_we = 0;
      step();
      vec++; if (n_rt !== 16'hBEEF) begin miss++; $display("FAIL bypass0_after got=%h exp=beef", n_rt); end
   endtask

   task automatic test_imm();
      idle();
      valid_in = 1; pc_add2_in = 16'hFFFE; imm_sel = 2'b01; imm_sign = 1;
      instr_in = 16'h0004;
      step();
      vec++; if (imm_out !== 16'h0004) begin miss++; $display("FAIL imm8_pos got=%h exp=0004", imm_out); end
      vec++; if (br_target !== 16'h0002) begin miss++; $display("FAIL br_wrap got=%h exp=0002", br_target); end
      instr_in = 16'h0080;
      step();
      vec++; if (imm_out !== 16'hFF80 || br_target !== 16'hFF7E) begin miss++; $display("FAIL imm8_neg got=%h/%h exp=ff80/ff7e", imm_out, br_target); end
      imm_sign = 0;
      step();
      vec++; if (imm_out !== 16'h0080 || br_target !== 16'h007E) begin miss++; $display("FAIL imm8_zext got=%h/%h exp=0080/007e", imm_out, br_target); end
      imm_sel = 2'b00; imm_sign = 1; instr_in = 16'h0010;
      step();
      vec++; if (imm_out !== 16'hFFF0) begin miss++; $display("FAIL imm5_neg got=%h exp=fff0", imm_out); end
      imm_sel = 2'b10; instr_in = 16'h0400;
      step();
      vec++; if (imm_out !== 16'hFC00) begin miss++; $display("FAIL imm11_neg got=%h exp=fc00", imm_out); end
      imm_sel = 2'b11; instr_in = 16'h07FF;
      step();
      vec++; if (imm_out !== 16'h0000 || br_target !== 16'hFFFE) begin miss++; $display("FAIL imm_zero got=%h/%h exp=0000/fffe", imm_out, br_target); end
      reg_dst = 2'b00; instr_in = 16'h0060;
      step();
      vec++; if (rd_sel !== 3'd3) begin miss++; $display("FAIL rd_00 got=%0d exp=3", rd_sel); end
      reg_dst = 2'b01; instr_in = 16'h0008;
      step();
      vec++; if (rd_sel !== 3'd2) begin miss++; $display("FAIL rd_01 got=%0d exp=2", rd_sel); end
      reg_dst = 2'b10; instr_in = 16'h0500;
      step();
      vec++; if (rd_sel !== 3'd5) begin miss++; $display("FAIL rd_10 got=%0d exp=5", rd_sel); end
      reg_dst = 2'b11; instr_in = 16'h0000;
      step();
      vec++; if (rd_sel !== 3'd7) begin miss++; $display("FAIL rd_11 got=%0d exp=7", rd_sel); end
   endtask

   task automatic test_stall_flush();
      idle();
      valid_in = 1; instr_in = 16'h0304; imm_sel = 2'b00;
      step();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         instr_in = 16'h0710 + 16'(i);
         imm_sel = 2'b10;
         wb_we = (i == 0); wb_sel = 3'd6; wb_data = 16'h5555;
         step();
         vec++;
         if (valid_out !== 1'b1 || rs_data !== 16'h1234 || imm_out !== 16'h0004 || rs_sel !== 3'd3) begin
            miss++;
            $display("FAIL stall_hold%0d got=%b/%h/%h/%0d exp=1/1234/0004/3", i, valid_out, rs_data, imm_out, rs_sel);
         end
      end
      wb_we = 0;
      flush = 1;
      step();
      vec++; if (valid_out !== 1'b0 || rs_data !== 16'h0 || imm_out !== 16'h0) begin miss++; $display("FAIL flush_stall got=%b/%h/%h exp=0/0000/0000", valid_out, rs_data, imm_out); end
      stall = 0; flush = 0; instr_in = 16'h0600; imm_sel = 2'b11;
      step();
      vec++; if (valid_out !== 1'b1 || rs_data !== 16'h5555) begin miss++; $display("FAIL write_in_stall got=%b/%h exp=1/5555", valid_out, rs_data); end
   endtask

   task automatic test_epc_nest();
      do_reset();
      valid_in = 1; instr_in = 16'h1000; pc_add2_in = 16'h0010;
      step();
      vec++; if (epc !== 16'h0010 || in_handler !== 1'b1 || is_siic !== 1'b1) begin miss++; $display("FAIL siic1 got=%h/%b/%b exp=0010/1/1", epc, in_handler, is_siic); end
      pc_add2_in = 16'h0020;
      step();
      vec++; if (epc !== 16'h0020) begin miss++; $display("FAIL siic2 got=%h exp=0020", epc); end
      instr_in = 16'h1800;
      step();
      vec++; if (epc !== 16'h0010 || is_rti !== 1'b1) begin miss++; $display("FAIL rti1 got=%h/%b exp=0010/1", epc, is_rti); end
      step();
      vec++; if (epc !== 16'h0000 || in_handler !== 1'b0 || exc_err !== 1'b0) begin miss++; $display("FAIL rti2 got=%h/%b/%b exp=0000/0/0", epc, in_handler, exc_err); end
      instr_in = 16'h1000;
      pc_add2_in = 16'h0010; step();
      pc_add2_in = 16'h0020; step();
      pc_add2_in = 16'h0030; step();
      vec++; if (exc_err !== 1'b1 || epc !== 16'h0020) begin miss++; $display("FAIL overflow got=%b/%h exp=1/0020", exc_err, epc); end
      instr_in = 16'h1800;
      step();
      vec++; if (epc !== 16'h0010 || exc_err !== 1'b1) begin miss++; $display("FAIL sticky got=%h/%b exp=0010/1", epc, exc_err); end
   endtask

   task automatic test_epc_edge();
      do_reset();
      valid_in = 1; instr_in = 16'h1800;
      step();
      vec++; if (exc_err !== 1'b1 || epc !== 16'h0 || in_handler !== 1'b0) begin miss++; $display("FAIL underflow got=%b/%h/%b exp=1/0000/0", exc_err, epc, in_handler); end
      do_reset();
      valid_in = 1; instr_in = 16'h1000; pc_add2_in = 16'h0050; stall = 1;
      step();
      vec++; if (in_handler !== 1'b0 || epc !== 16'h0) begin miss++; $display("FAIL siic_stall got=%b/%h exp=0/0000", in_handler, epc); end
      stall = 0; flush = 1;
      step();
      vec++; if (in_handler !== 1'b0) begin miss++; $display("FAIL siic_flush got=%b exp=0", in_handler); end
      flush = 0; valid_in = 0;
      step();
      vec++; if (in_handler !== 1'b0) begin miss++; $display("FAIL siic_invalid got=%b exp=0", in_handler); end
      valid_in = 1;
      step();
      vec++; if (in_handler !== 1'b1 || epc !== 16'h0050) begin miss++; $display("FAIL siic_go got=%b/%h exp=1/0050", in_handler, epc); end
      rst = 0; idle();
      step();
      rst = 1;
      vec++; if (in_handler !== 1'b0 || epc !== 16'h0 || exc_err !== 1'b0) begin miss++; $display("FAIL reset_mid got=%b/%h/%b exp=0/0000/0", in_handler, epc, exc_err); end
   endtask

   initial begin
      rst = 0;
      idle();
      test_reset();
      test_bypass();
      test_imm();
      test_stall_flush();
      test_epc_nest();
      test_epc_edge();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
